// File: rtl/sound_adc8_pkg.sv
// Shared sound-path definitions (sample width and full-scale code), also used by the DAC.
package sound_adc8_pkg;

  localparam int unsigned SOUND_SAMPLE_W = 8;
  localparam logic [SOUND_SAMPLE_W-1:0] SOUND_SAMPLE_MAX = 8'hFF;

endpackage

// File: rtl/sound_adc8_sync2.sv
// Two-flop synchronizer for asynchronous single-bit audio inputs.
module sound_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two register stages to let a metastable first stage settle before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sound_adc8.sv
// First-order delta-sigma ADC receiver: samples the external comparator, drives the
// 1-bit feedback and boxcar-decimates its ones density into 8-bit unsigned samples.
module sound_adc8
  import sound_adc8_pkg::*;
#(
  parameter int unsigned OSR_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      comp_in,
  output logic                      fb_out,
  output logic [SOUND_SAMPLE_W-1:0] sample,
  output logic                      sample_valid,
  input  logic                      sample_rd,
  output logic                      overrun
);

  logic                      comp_sync;
  logic [OSR_LOG2-1:0]       win_cnt;
  logic [OSR_LOG2:0]         acc;
  logic [OSR_LOG2:0]         total;
  logic                      win_done;
  logic [SOUND_SAMPLE_W-1:0] win_sample;

  sound_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (comp_in),
    .q   (comp_sync)
  );

  // Feedback follows the synchronized comparator every clock, independent of en.
  always_ff @(posedge clk) begin
    if (rst) fb_out <= 1'b0;
    else     fb_out <= comp_sync;
  end

  // Window total including this cycle's bit; an all-ones window sets only the MSB,
  // which saturates to full scale instead of wrapping to zero.
  always_comb begin
    total      = acc + {{OSR_LOG2{1'b0}}, fb_out};
    win_done   = en && (win_cnt == '1);
    win_sample = total[OSR_LOG2] ? SOUND_SAMPLE_MAX
                                 : total[OSR_LOG2-1 -: SOUND_SAMPLE_W];
  end

  // Window counter and ones accumulator; both freeze while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      acc     <= '0;
    end else if (en) begin
      win_cnt <= win_cnt + 1'b1;
      acc     <= win_done ? '0 : total;
    end
  end

  // Sample register and consumer handshake; a completion takes precedence over a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (win_done) begin
      sample <= win_sample;
      if (!sample_valid)   sample_valid <= 1'b1;
      else if (!sample_rd) overrun      <= 1'b1;
    end else if (sample_rd && sample_valid) begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end
  end

endmodule
